// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one full-adder cell computing a + ~b + 1.
// Optional macro SERIAL_SUB_OVF_EN adds the ovf port (two's-complement overflow of a - b).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             carry_q,  carry_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic             nb;
   logic             bit_s;
   logic             carry_out;
   logic [WIDTH-1:0] res_shifted;

   // One full-adder cell on the current LSBs; subtrahend is inverted, carry seeded with 1.
   always_comb begin
      nb          = ~b_sh_q[0];
      bit_s       = a_sh_q[0] ^ nb ^ carry_q;
      carry_out   = (a_sh_q[0] & nb) | (a_sh_q[0] & carry_q) | (nb & carry_q);
      res_shifted = {bit_s, res_sh_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_shifted;
            carry_d  = carry_out;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               diff_d   = res_shifted;
               borrow_d = ~carry_out;
`ifdef SERIAL_SUB_OVF_EN
               // carry_q here is the carry into the MSB cell
               ovf_d    = carry_q ^ carry_out;
`endif
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
